div_share_ctrl: RTL and testbench
=================================

Name: div_share_ctrl

Overview:
Sequencing controller that shares one multi-cycle sequential divider among NUM_REQ requesters.
- Accepts division requests on per-requester valid/ready ports and picks one by round-robin.
- Drives the divider's level start/operand interface and captures the quotient and remainder when the divider pulses done.
- Returns the result with the winning requester's one-hot id on a single valid/ready response port.
- Sits between the accelerator's requesting engines and the shared divider instance.

Parameters:
WIDTH, 8, operand/quotient/remainder width; must match the divider instance.
NUM_REQ, 4, number of requesters, 2..8.
TIMEOUT, 64, RUN-state cycle limit before abort; must be > WIDTH+2.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  one-hot accept pulse
req_dividend  input  NUM_REQ*WIDTH  requester i at bits [i*WIDTH +: WIDTH]
req_divisor  input  NUM_REQ*WIDTH  same packing
div_start  output  1  divider start level; held high for the whole operation
div_dividend  output  WIDTH  latched dividend, stable while div_start=1
div_divisor  output  WIDTH  latched divisor, stable while div_start=1
div_done  input  1  divider one-cycle done pulse
div_q  input  WIDTH  divider quotient, valid in the div_done cycle
div_r  input  WIDTH  divider remainder, valid in the div_done cycle
rsp_valid  output  1  response valid, held until accepted
rsp_ready  input  1  response consumer ready
rsp_id  output  NUM_REQ  one-hot id of the served requester
rsp_q  output  WIDTH  quotient
rsp_r  output  WIDTH  remainder
rsp_err  output  1  1 = divide-by-zero (optional feature) or timeout

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Outputs are registered unless noted.
- Reset values:
  - State=IDLE; req_ready, div_start, rsp_valid, rsp_err = 0.
  - rsp_id, rsp_q, rsp_r, div_dividend, div_divisor = 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 wins first.
- States: IDLE, RUN, GAP, RESP.
- IDLE, with any req_valid set:
  - Search starts at pointer+1 and wraps; the first set bit wins.
  - req_ready pulses for exactly one cycle on the winner only (combinational from state and arbitration).
  - Winner's operands are latched to div_dividend/div_divisor and its id to rsp_id; pointer is set to the winner.
  - Next state is RUN, with div_start=1 from the next cycle.
- IDLE with no req_valid: stay; req_ready=0.
- RUN:
  - div_start=1; a watchdog counts cycles from 0.
  - div_done=1: latch div_q to rsp_q and div_r to rsp_r, rsp_err=0, then go to GAP.
  - Watchdog reaches TIMEOUT-1 without done: rsp_q=all ones, rsp_r=0, rsp_err=1, then go to GAP.
- GAP: div_start=0 for exactly one cycle to clear the divider; go to RESP.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_valid&&rsp_ready.
  - On that handshake: rsp_valid=0 next cycle and go to IDLE.
  - New requests are not accepted during RUN, GAP or RESP.
- Minimum request-to-request spacing (rsp_ready tied 1): accept, RUN (divider latency), GAP, RESP, IDLE. Back-to-back grants are separated by at least 3 controller cycles plus the divider run.
- Requester protocol: operands stay stable while valid=1 and not yet accepted. Dropping valid before accept is legal; the request is simply not served.
- Simultaneous events:
  - div_done in the same cycle the watchdog expires: done wins, rsp_err=0.
  - div_done outside RUN is ignored.
- Reset mid-operation: from any state, return to IDLE next cycle, with div_start=0 and any pending response dropped.

Optional Feature:
DIV_SHARE_ZERO_BYPASS_EN.
- Defined: a request accepted with divisor==0 skips RUN and GAP and goes directly to RESP. div_start stays 0 and the response is rsp_q=all ones, rsp_r=dividend, rsp_err=1.
- Undefined: zero divisors go to the divider as normal. The response is whatever div_q/div_r return with rsp_err=0, or the timeout path if done never comes.

Test Plan:
1. Single request: req_valid=0001, dividend 200, divisor 7, rsp_ready=1 -> one req_ready pulse on bit 0; div_start high until div_done; rsp_q=28, rsp_r=4, rsp_id=0001, rsp_err=0.
2. Round-robin fairness: req_valid=1111 held, each requester 100/10, 8 operations -> grant order 0,1,2,3,0,1,2,3; every rsp_q=10, rsp_r=0.
3. Backpressure: rsp_ready=0 for 20 cycles after rsp_valid -> rsp_* stable; no req_ready asserted; handshake on rsp_ready=1; IDLE next cycle.
4. Timeout: divider model never asserts div_done -> after TIMEOUT RUN cycles, rsp_err=1, rsp_q=0xFF, rsp_r=0 (WIDTH=8); div_start low in GAP.
5. Divide by zero, 9/0: with DIV_SHARE_ZERO_BYPASS_EN -> div_start never high; rsp_q=0xFF, rsp_r=9, rsp_err=1. Without it -> divider is run and rsp_err=0.
6. Reset mid-RUN: assert rst during cycle 3 of RUN -> next cycle div_start=0, rsp_valid=0, state IDLE; pending requester 2 served first after release (pointer reset).

Source files
------------

// File: rtl/div_share_ctrl_if.sv
// div_share_ctrl_if: request, divider and response signals of the shared-divider controller.
// The master side is the controller; the slave side is the requesters, divider and response consumer.
interface div_share_ctrl_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_dividend;
    logic [NUM_REQ*WIDTH-1:0] req_divisor;
    logic                     div_start;
    logic [WIDTH-1:0]         div_dividend;
    logic [WIDTH-1:0]         div_divisor;
    logic                     div_done;
    logic [WIDTH-1:0]         div_q;
    logic [WIDTH-1:0]         div_r;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [NUM_REQ-1:0]       rsp_id;
    logic [WIDTH-1:0]         rsp_q;
    logic [WIDTH-1:0]         rsp_r;
    logic                     rsp_err;

    modport master (
        input  req_valid, req_dividend, req_divisor, div_done, div_q, div_r, rsp_ready,
        output req_ready, div_start, div_dividend, div_divisor, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err
    );
    modport slave (
        output req_valid, req_dividend, req_divisor, div_done, div_q, div_r, rsp_ready,
        input  req_ready, div_start, div_dividend, div_divisor, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err
    );
endinterface

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: round-robin sharing of one multi-cycle divider among NUM_REQ requesters.
// Define DIV_SHARE_ZERO_BYPASS_EN to answer zero-divisor requests directly without the divider.
module div_share_ctrl #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input logic              clk,
    input logic              rst,
    div_share_ctrl_if.master bus
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, RUN, GAP, RESP} state_t;

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    win;
    logic [PW-1:0]    idx;
    logic             found;
    logic [WW-1:0]    wd;
    logic [WIDTH-1:0] dvd [NUM_REQ];
    logic [WIDTH-1:0] dvs [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign dvd[i] = bus.req_dividend[i*WIDTH +: WIDTH];
        assign dvs[i] = bus.req_divisor[i*WIDTH +: WIDTH];
    end

    // Search starts one past the last winner and wraps, so the first set bit found is the grant.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx   = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (idx == PW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign bus.req_ready = (state == IDLE && found) ? NUM_REQ'(1) << win : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            ptr              <= PW'(NUM_REQ - 1);
            wd               <= '0;
            bus.div_start    <= 1'b0;
            bus.div_dividend <= '0;
            bus.div_divisor  <= '0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_err      <= 1'b0;
            bus.rsp_id       <= '0;
            bus.rsp_q        <= '0;
            bus.rsp_r        <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    ptr              <= win;
                    wd               <= '0;
                    bus.div_dividend <= dvd[win];
                    bus.div_divisor  <= dvs[win];
                    bus.rsp_id       <= bus.req_ready;
`ifdef DIV_SHARE_ZERO_BYPASS_EN
                    if (dvs[win] == '0) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_q     <= '1;
                        bus.rsp_r     <= dvd[win];
                        bus.rsp_err   <= 1'b1;
                    end else begin
                        state         <= RUN;
                        bus.div_start <= 1'b1;
                    end
`else
                    state         <= RUN;
                    bus.div_start <= 1'b1;
`endif
                end
                RUN: begin
                    // A done arriving on the watchdog's last cycle still counts as success.
                    if (bus.div_done) begin
                        state         <= GAP;
                        bus.div_start <= 1'b0;
                        bus.rsp_q     <= bus.div_q;
                        bus.rsp_r     <= bus.div_r;
                        bus.rsp_err   <= 1'b0;
                    end else if (wd == WW'(TIMEOUT - 1)) begin
                        state         <= GAP;
                        bus.div_start <= 1'b0;
                        bus.rsp_q     <= '1;
                        bus.rsp_r     <= '0;
                        bus.rsp_err   <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                GAP: begin
                    state         <= RESP;
                    bus.rsp_valid <= 1'b1;
                end
                RESP: if (bus.rsp_ready) begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_share_ctrl.sv
// tb_div_share_ctrl: randomized scenario bench for div_share_ctrl with a behavioural divider and arbiter model.
// Expected results come from plain arithmetic and a round-robin pick over the request mask.
module tb_div_share_ctrl;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_share_ctrl_if #(.WIDTH(W), .NUM_REQ(N)) dut_if ();
    div_share_ctrl #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(dut_if));

    int tests = 0;
    int fails = 0;
    int mptr  = N - 1;

    int         lat   = 3;
    bit         hang  = 1'b0;
    logic       spur  = 1'b0;
    logic       dd    = 1'b0;
    int         cnt   = 0;
    bit         fired = 1'b0;
    int         n_start = 0;
    logic [W-1:0] mq = '0;
    logic [W-1:0] mr = '0;

    assign dut_if.div_done = dd | spur;
    assign dut_if.div_q    = spur ? 8'hA5 : mq;
    assign dut_if.div_r    = spur ? 8'h5A : mr;

    // Divider model: pulses done lat cycles after start rises, restoring-divider result for zero divisor.
    always @(posedge clk) begin
        dd <= 1'b0;
        if (!dut_if.div_start) begin
            cnt   <= 0;
            fired <= 1'b0;
        end else begin
            cnt <= cnt + 1;
            if (cnt + 1 >= lat && !hang && !fired) begin
                dd    <= 1'b1;
                fired <= 1'b1;
                mq    <= (dut_if.div_divisor == 0) ? '1 : dut_if.div_dividend / dut_if.div_divisor;
                mr    <= (dut_if.div_divisor == 0) ? dut_if.div_dividend : dut_if.div_dividend % dut_if.div_divisor;
            end
        end
    end

    always @(negedge clk) if (dut_if.div_start) n_start <= n_start + 1;

    function automatic int pick(input logic [N-1:0] m);
        for (int k = 1; k <= N; k++) if (m[(mptr + k) % N]) return (mptr + k) % N;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        dut_if.req_dividend[i*W +: W] = a;
        dut_if.req_divisor[i*W +: W]  = b;
    endtask

    // Waits for a grant and the response, holding rsp_ready low for rdy_wait cycles; reports observations only.
    task automatic serve(input int rdy_wait, input bit drop, output bit to, output logic [N-1:0] g,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic [N-1:0] id,
                         output logic err, output bit stable, output bit rr_seen, output logic hs_valid);
        to = 1'b1; g = '0; q = '0; r = '0; id = '0; err = 1'b0; stable = 1'b1; rr_seen = 1'b0; hs_valid = 1'b1;
        dut_if.rsp_ready = 1'b0;
        for (int c = 0; c < 200; c++) begin
            #1;
            g = dut_if.req_ready;
            if (g != 0) break;
            @(negedge clk);
        end
        if (g == 0) return;
        @(negedge clk);
        if (drop) dut_if.req_valid = dut_if.req_valid & ~g;
        for (int c = 0; c < TO + 200; c++) begin
            #1;
            if (dut_if.rsp_valid === 1'b1) break;
            if (dut_if.req_ready != 0) rr_seen = 1'b1;
            @(negedge clk);
        end
        if (dut_if.rsp_valid !== 1'b1) return;
        q = dut_if.rsp_q; r = dut_if.rsp_r; id = dut_if.rsp_id; err = dut_if.rsp_err;
        for (int c = 0; c < rdy_wait; c++) begin
            @(negedge clk);
            spur = (c == 1);
            #1;
            if (dut_if.req_ready != 0) rr_seen = 1'b1;
            if (dut_if.rsp_valid !== 1'b1 || dut_if.rsp_q !== q || dut_if.rsp_r !== r ||
                dut_if.rsp_id !== id || dut_if.rsp_err !== err) stable = 1'b0;
        end
        spur = 1'b0;
        dut_if.rsp_ready = 1'b1;
        @(negedge clk);
        hs_valid = dut_if.rsp_valid;
        to = 1'b0;
    endtask

    task automatic test_reset();
        logic [N-1:0] exp_g;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if ({dut_if.div_start, dut_if.rsp_valid, dut_if.rsp_err, dut_if.rsp_id, dut_if.rsp_q, dut_if.rsp_r,
             dut_if.div_dividend, dut_if.div_divisor, dut_if.req_ready} !== '0) begin
            fails++;
            $display("FAIL reset_values: got start=%b valid=%b err=%b id=%h q=%h r=%h dd=%h dv=%h rdy=%h required all zero",
                     dut_if.div_start, dut_if.rsp_valid, dut_if.rsp_err, dut_if.rsp_id, dut_if.rsp_q, dut_if.rsp_r,
                     dut_if.div_dividend, dut_if.div_divisor, dut_if.req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        mptr = N - 1;
        dut_if.req_valid = '1;
        exp_g = N'(1) << pick('1);
        #1;
        tests++;
        if (dut_if.req_ready !== exp_g) begin
            fails++;
            $display("FAIL reset_first_grant: got %b required %b", dut_if.req_ready, exp_g);
        end
        #1 dut_if.req_valid = '0;
    endtask

    task automatic test_single();
        bit to, st, rs; logic [N-1:0] g, id; logic [W-1:0] q, r; logic err, hv;
        set_req(0, 8'd200, 8'd7);
        lat = 5;
        dut_if.req_valid = 4'b0001;
        serve(0, 1'b1, to, g, q, r, id, err, st, rs, hv);
        mptr = 0;
        tests++;
        if (to !== 1'b0 || g !== 4'b0001 || rs !== 1'b0) begin
            fails++;
            $display("FAIL single_grant: got timeout=%b grant=%b extra_ready=%b required 0 0001 0", to, g, rs);
        end
        tests++;
        if (q !== 8'd28 || r !== 8'd4 || id !== 4'b0001 || err !== 1'b0) begin
            fails++;
            $display("FAIL single_result: got q=%0d r=%0d id=%b err=%b required q=28 r=4 id=0001 err=0", q, r, id, err);
        end
        tests++;
        if (dut_if.div_dividend !== 8'd200 || dut_if.div_divisor !== 8'd7) begin
            fails++;
            $display("FAIL single_latched_ops: got %0d/%0d required 200/7", dut_if.div_dividend, dut_if.div_divisor);
        end
    endtask

    task automatic test_round_robin();
        bit to, st, rs; logic [N-1:0] g, id, exp_g; logic [W-1:0] q, r; logic err, hv;
        for (int i = 0; i < N; i++) set_req(i, 8'd100, 8'd10);
        lat = 2;
        dut_if.req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            exp_g = N'(1) << pick('1);
            mptr = pick('1);
            serve(0, 1'b0, to, g, q, r, id, err, st, rs, hv);
            if (k == 7) dut_if.req_valid = '0;
            tests++;
            if (to !== 1'b0 || g !== exp_g || id !== exp_g || q !== 8'd10 || r !== 8'd0 || err !== 1'b0) begin
                fails++;
                $display("FAIL round_robin op %0d: got to=%b grant=%b id=%b q=%0d r=%0d err=%b required grant=%b q=10 r=0 err=0",
                         k, to, g, id, q, r, err, exp_g);
            end
        end
    endtask

    task automatic test_backpressure();
        bit to, st, rs; logic [N-1:0] g, id, exp_g, exp_next; logic [W-1:0] q, r, a, b; logic err, hv;
        a = W'($urandom); b = W'($urandom_range(1, 255));
        set_req(1, a, b);
        set_req(3, 8'd50, 8'd5);
        lat = 4;
        dut_if.req_valid = 4'b1010;
        exp_g = N'(1) << pick(4'b1010);
        mptr = pick(4'b1010);
        serve(20, 1'b1, to, g, q, r, id, err, st, rs, hv);
        #1;
        exp_next = N'(1) << pick(4'b1000);
        tests++;
        if (to !== 1'b0 || g !== exp_g || q !== a / b || r !== a % b || err !== 1'b0) begin
            fails++;
            $display("FAIL bp_result: got to=%b grant=%b q=%0d r=%0d err=%b required grant=%b q=%0d r=%0d err=0",
                     to, g, q, r, err, exp_g, a / b, a % b);
        end
        tests++;
        if (st !== 1'b1 || rs !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold: got stable=%b ready_seen=%b required 1 0", st, rs);
        end
        tests++;
        if (hv !== 1'b0 || dut_if.req_ready !== exp_next) begin
            fails++;
            $display("FAIL bp_release: got rsp_valid=%b req_ready=%b required 0 %b", hv, dut_if.req_ready, exp_next);
        end
        dut_if.req_valid = '0;
    endtask

    task automatic test_timeout();
        bit to, st, rs; logic [N-1:0] g, id; logic [W-1:0] q, r; logic err, hv; int n0;
        set_req(2, 8'd77, 8'd3);
        hang = 1'b1;
        n0 = n_start;
        dut_if.req_valid = 4'b0100;
        mptr = 2;
        serve(0, 1'b1, to, g, q, r, id, err, st, rs, hv);
        tests++;
        if (to !== 1'b0 || err !== 1'b1 || q !== 8'hFF || r !== 8'h00 || id !== 4'b0100) begin
            fails++;
            $display("FAIL timeout_result: got to=%b err=%b q=%h r=%h id=%b required 0 1 ff 00 0100", to, err, q, r, id);
        end
        tests++;
        if (n_start - n0 !== TO || dut_if.div_start !== 1'b0) begin
            fails++;
            $display("FAIL timeout_run_len: got %0d start cycles (start now %b) required %0d (0)",
                     n_start - n0, dut_if.div_start, TO);
        end
        hang = 1'b0;
    endtask

    task automatic test_div_zero();
        bit to, st, rs; logic [N-1:0] g, id; logic [W-1:0] q, r; logic err, hv; int n0;
        set_req(3, 8'd9, 8'd0);
        lat = 3;
        n0 = n_start;
        dut_if.req_valid = 4'b1000;
        mptr = 3;
        serve(0, 1'b1, to, g, q, r, id, err, st, rs, hv);
        tests++;
`ifdef DIV_SHARE_ZERO_BYPASS_EN
        if (to !== 1'b0 || q !== 8'hFF || r !== 8'd9 || err !== 1'b1 || n_start != n0) begin
            fails++;
            $display("FAIL div_zero: got to=%b q=%h r=%0d err=%b starts=%0d required 0 ff 9 1 0", to, q, r, err, n_start - n0);
        end
`else
        if (to !== 1'b0 || q !== 8'hFF || r !== 8'd9 || err !== 1'b0 || n_start == n0) begin
            fails++;
            $display("FAIL div_zero: got to=%b q=%h r=%0d err=%b starts=%0d required 0 ff 9 0 nonzero", to, q, r, err, n_start - n0);
        end
`endif
    endtask

    task automatic test_reset_mid_run();
        bit to, st, rs; logic [N-1:0] g, id, exp_g; logic [W-1:0] q, r; logic err, hv;
        set_req(2, 8'd60, 8'd7);
        set_req(3, 8'd40, 8'd4);
        hang = 1'b1;
        dut_if.rsp_ready = 1'b1;
        dut_if.req_valid = 4'b0100;
        #1;
        tests++;
        if (dut_if.req_ready !== 4'b0100) begin
            fails++;
            $display("FAIL mid_reset_grant: got %b required 0100", dut_if.req_ready);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        dut_if.req_valid = 4'b1100;
        @(negedge clk);
        #1;
        tests++;
        if (dut_if.div_start !== 1'b0 || dut_if.rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_clear: got start=%b valid=%b required 0 0", dut_if.div_start, dut_if.rsp_valid);
        end
        rst = 1'b0;
        mptr = N - 1;
        hang = 1'b0;
        exp_g = N'(1) << pick(4'b1100);
        mptr = pick(4'b1100);
        serve(0, 1'b1, to, g, q, r, id, err, st, rs, hv);
        dut_if.req_valid = '0;
        tests++;
        if (to !== 1'b0 || g !== exp_g || q !== 8'd8 || r !== 8'd4 || err !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_after: got to=%b grant=%b q=%0d r=%0d err=%b required grant=%b q=8 r=4 err=0",
                     to, g, q, r, err, exp_g);
        end
    endtask

    task automatic test_random();
        bit to, st, rs; logic [N-1:0] g, id, m, exp_g; logic [W-1:0] q, r, eq, er; logic err, hv, ee;
        logic [W-1:0] a [N];
        logic [W-1:0] b [N];
        int w;
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < N; i++) begin
                a[i] = W'($urandom);
                b[i] = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 255));
                set_req(i, a[i], b[i]);
            end
            m = N'($urandom_range(1, (1 << N) - 1));
            lat = $urandom_range(1, W + 2);
            w = pick(m);
            exp_g = N'(1) << w;
            mptr = w;
            eq = (b[w] == 0) ? '1 : a[w] / b[w];
            er = (b[w] == 0) ? a[w] : a[w] % b[w];
`ifdef DIV_SHARE_ZERO_BYPASS_EN
            ee = (b[w] == 0);
`else
            ee = 1'b0;
`endif
            dut_if.req_valid = m;
            serve($urandom_range(0, 3), 1'b1, to, g, q, r, id, err, st, rs, hv);
            dut_if.req_valid = '0;
            tests++;
            if (to !== 1'b0 || g !== exp_g || id !== exp_g || q !== eq || r !== er || err !== ee || st !== 1'b1) begin
                fails++;
                $display("FAIL random %0d: got to=%b grant=%b id=%b q=%h r=%h err=%b stable=%b required grant=%b q=%h r=%h err=%b",
                         t, to, g, id, q, r, err, st, exp_g, eq, er, ee);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        dut_if.req_valid    = '0;
        dut_if.req_dividend = '0;
        dut_if.req_divisor  = '0;
        dut_if.rsp_ready    = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_div_zero();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
